// File: rtl/draw_packet_tx_scheduler.sv
// Queues draw points and serialises each into a 4-byte packet {col, row[7:0], {color,0000,row[8]}, TERMINATOR}
// for bluetooth_tx, pacing bytes on tx_done_in and aborting a byte that stalls past TIMEOUT_CYCLES.
module draw_packet_tx_scheduler #(
  parameter int         FIFO_DEPTH     = 8,
  parameter logic [7:0] TERMINATOR     = 8'h0A,
  parameter int         TIMEOUT_CYCLES = 2_000_000
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          enable_in,
  input  logic                          point_valid_in,
  input  logic [7:0]                    point_col_in,
  input  logic [8:0]                    point_row_in,
  input  logic [2:0]                    point_color_in,
  output logic                          point_ready_out,
  input  logic                          tx_busy_in,
  input  logic                          tx_done_in,
  output logic                          tx_start_out,
  output logic [7:0]                    tx_data_out,
  output logic                          packet_sent_out,
  output logic                          timeout_out,
  output logic                          overflow_out,
  output logic [7:0]                    drop_count_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_out,
  output logic                          busy_out
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [AW:0]   DEPTH   = (AW+1)'(FIFO_DEPTH);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef struct packed {
    logic [2:0] color;
    logic [8:0] row;
    logic [7:0] col;
  } point_t;

  typedef enum logic [1:0] {IDLE, LOAD, SEND, WAIT} state_t;

  state_t        state, state_nxt;
  point_t        mem [FIFO_DEPTH];
  point_t        pkt;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_nxt;
  logic          ready;
  logic [1:0]    byte_idx;
  logic [TW-1:0] to_cnt;
  logic          push, pop, drop, empty, full;
  logic          start, last_done, to_hit;
  logic [7:0]    tx_byte;

  assign full  = (count == DEPTH);
  assign empty = (count == '0);
  assign push  = point_valid_in && ready;
  assign drop  = point_valid_in && full;
  assign pop   = (state == LOAD);

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (push) mem[wr_ptr] <= '{color: point_color_in, row: point_row_in, col: point_col_in};
  end

  // ready is registered so it reads 0 while reset is held and follows !full afterwards
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      ready      <= 1'b0;
      pkt        <= '0;
      overflow_out   <= 1'b0;
      drop_count_out <= '0;
    end else begin
      count <= count_nxt;
      ready <= (count_nxt != DEPTH);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        pkt    <= mem[rd_ptr];
      end
      if (drop) begin
        overflow_out <= 1'b1;
        if (drop_count_out != 8'hFF) drop_count_out <= drop_count_out + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    last_done = 1'b0;
    to_hit    = 1'b0;
    unique case (state)
      IDLE: if (enable_in && !empty && !tx_busy_in) state_nxt = LOAD;
      LOAD: state_nxt = SEND;
      SEND: if (!tx_busy_in) begin
        start     = 1'b1;
        state_nxt = WAIT;
      end
      // a done on the terminal-count cycle wins over the timeout
      WAIT: if (tx_done_in) begin
        if (byte_idx == 2'd3) begin
          last_done = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = SEND;
        end
      end else if (to_cnt == TO_LAST) begin
        to_hit    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state    <= IDLE;
      byte_idx <= '0;
      to_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == LOAD) byte_idx <= '0;
      else if (state == WAIT && tx_done_in && byte_idx != 2'd3) byte_idx <= byte_idx + 1'b1;
      if (start) to_cnt <= '0;
      else if (state == WAIT) to_cnt <= to_cnt + 1'b1;
    end
  end

  always_comb begin
    tx_byte = TERMINATOR;
    case (byte_idx)
      2'd0:    tx_byte = pkt.col;
      2'd1:    tx_byte = pkt.row[7:0];
      2'd2:    tx_byte = {pkt.color, 4'b0000, pkt.row[8]};
      default: tx_byte = TERMINATOR;
    endcase
  end

  assign tx_data_out     = (state == SEND || state == WAIT) ? tx_byte : 8'h00;
  assign tx_start_out    = start;
  assign packet_sent_out = last_done;
  assign timeout_out     = to_hit;
  assign point_ready_out = ready;
  assign fifo_count_out  = count;
  assign busy_out        = (state != IDLE);
endmodule
